// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile geometry constants and scheduler state encoding
// Purpose: constants common to the tile scheduler, the tile drawer and later sprite stages.
// Ports:   none (package).
// Config:  BLANK_TILE is only acted on when TILE_SKIP_EN is defined.
package tile_pkg;

  localparam int TILE_W       = 8;
  localparam int BYTES_PER_PX = 3;
  localparam int TILE_BYTES   = 192;
  localparam int TILE_ADDR_W  = 12;

  localparam logic [7:0] BLANK_TILE = 8'hFF;

  // Scheduler states, 8-bit wide to match the drawer's encoding.
  localparam logic [7:0] S_IDLE      = 8'd0;
  localparam logic [7:0] S_FETCH     = 8'd1;
  localparam logic [7:0] S_CALC      = 8'd2;
  localparam logic [7:0] S_ISSUE     = 8'd3;
  localparam logic [7:0] S_WAIT_ACK  = 8'd4;
  localparam logic [7:0] S_WAIT_DONE = 8'd5;
  localparam logic [7:0] S_ADVANCE   = 8'd6;
  localparam logic [7:0] S_DONE      = 8'd7;

endpackage

// File: rtl/tile_addr_calc.sv
// rtl/tile_addr_calc.sv - combinational tile index to pixel-ROM byte address
// Purpose: addr = idx * 192 built as (idx<<7)+(idx<<6), truncated to TILE_ADDR_W bits.
// Ports:   idx  in  8            tile index
//          addr out TILE_ADDR_W  byte address of the tile's first pixel
module tile_addr_calc
  import tile_pkg::*;
(
  input  logic [7:0]             idx,
  output logic [TILE_ADDR_W-1:0] addr
);

  logic [TILE_ADDR_W-1:0] idx_w;

  assign idx_w = TILE_ADDR_W'(idx);
  // Indices of 22 and above overflow 12 bits and wrap; the pixel ROM only decodes 12 bits.
  assign addr  = (idx_w << 7) + (idx_w << 6);

endmodule

// File: rtl/tilemap_scheduler.sv
// rtl/tilemap_scheduler.sv - walks the tile map and issues one draw job at a time
// Purpose: reads MAP_COLS x MAP_ROWS tile indices from map ROM in raster order and hands each
//          to the tile drawer as (tile_address, x_pos, y_pos) with a one-cycle draw pulse.
// Ports:   clk, reset (sync, active-high)
//          start in / busy out / done out       frame handshake with the game controller
//          map_rom_address out / map_rom_data in map ROM read port (MAP_ROM_LAT cycles latency)
//          tile_address, x_pos, y_pos, draw out job to the tile drawer
//          drawer_active in                     drawer busy flag
// Config:  define TILE_SKIP_EN to skip map entries equal to BLANK_TILE (no draw issued).
module tilemap_scheduler
  import tile_pkg::*;
#(
  parameter int MAP_COLS    = 20,
  parameter int MAP_ROWS    = 15,
  parameter int MAP_AW      = 9,
  parameter int MAP_ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [MAP_AW-1:0] map_rom_address,
  input  logic [7:0]        map_rom_data,
  output logic [11:0]       tile_address,
  output logic [7:0]        x_pos,
  output logic [7:0]        y_pos,
  output logic              draw,
  input  logic              drawer_active
);

  localparam int COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam int ROW_W = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;

  logic [7:0]             state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [1:0]             wait_q, wait_d;
  logic [MAP_AW-1:0]      addr_q, addr_d;
  logic [TILE_ADDR_W-1:0] tile_q, tile_d;
  logic [7:0]             x_q, x_d;
  logic [7:0]             y_q, y_d;
  logic                   draw_q, draw_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [TILE_ADDR_W-1:0] calc_addr;
  logic                   last_col, last_tile;

  tile_addr_calc u_addr_calc (
    .idx  (map_rom_data),
    .addr (calc_addr)
  );

  assign last_col  = (col_q == COL_W'(MAP_COLS - 1));
  assign last_tile = last_col && (row_q == ROW_W'(MAP_ROWS - 1));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    tile_d  = tile_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    draw_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          wait_d  = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Address was updated on entry, so map_rom_data is valid on the first S_CALC cycle.
        if (wait_q == 2'(MAP_ROM_LAT - 1)) begin
          wait_d  = '0;
          state_d = S_CALC;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_CALC: begin
`ifdef TILE_SKIP_EN
        if (map_rom_data == BLANK_TILE) begin
          state_d = S_ADVANCE;
        end else
`endif
        begin
          tile_d  = calc_addr;
          x_d     = 8'({col_q, 3'b000});
          y_d     = 8'({row_q, 3'b000});
          draw_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (drawer_active) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!drawer_active) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (last_tile) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          // Raster order makes the map address a plain running counter.
          addr_d = addr_q + MAP_AW'(1);
          if (last_col) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      tile_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      draw_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      tile_q  <= tile_d;
      x_q     <= x_d;
      y_q     <= y_d;
      draw_q  <= draw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign map_rom_address = addr_q;
  assign tile_address    = tile_q;
  assign x_pos           = x_q;
  assign y_pos           = y_q;
  assign draw            = draw_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
